sprite_bank: RTL and testbench

Parametrised per-scanline sprite pixel engine for the PPU. It holds NUM_SPR sprite slots, each with double-buffered pattern, attribute and X registers, plus its own shifters and X down-counter. It replaces per-slot instantiation with one block that resolves priority between slots internally. Staging is written during sprite fetch (cycles 257–320), promoted to the active set at line start, then shifted out over visible cycles 1–256, producing one registered sprite pixel per px_en.

---
 rtl/sprite_bank.sv | 148 ++++++++++++++
 tb/tb_sprite_bank.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_bank.sv
// Per-scanline sprite pixel engine: NUM_SPR double-buffered slots, internal priority.
// Optional macro SPR_ZERO_HIT_EN enables the sprite-0 flag register and spr0_px output.
module sprite_bank #(
  parameter int NUM_SPR = 8,
  localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              px_en,
  input  logic              line_start,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [1:0]        wr_sel,
  input  logic [7:0]        wr_data,
  input  logic              spr0_in,
  output logic [3:0]        px,
  output logic              pri,
  output logic              spr0_px
);

  // Staging set; attr keeps only the bits that matter: {flip, pri, pal[1:0]}
  logic [NUM_SPR-1:0] st_valid;
  logic [3:0]         st_attr [NUM_SPR];
  logic [7:0]         st_pat0 [NUM_SPR];
  logic [7:0]         st_pat1 [NUM_SPR];
  logic [7:0]         st_x    [NUM_SPR];

  // Active set; a_attr = {pri, pal[1:0]}
  logic [NUM_SPR-1:0] act_valid;
  logic [2:0]         a_attr [NUM_SPR];
  logic [7:0]         sr0    [NUM_SPR];
  logic [7:0]         sr1    [NUM_SPR];
  logic [7:0]         xc     [NUM_SPR];

  logic       wr_hit;
  logic [7:0] wr_pat;
  logic [3:0] win_px;
  logic       win_pri;
  logic       found;
  logic [1:0] cand;

  function automatic logic [7:0] bit_rev(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int unsigned b = 0; b < 8; b++) r[b] = d[7-b];
    return r;
  endfunction

  assign wr_hit = wr_en && (int'(wr_slot) < NUM_SPR);
  assign wr_pat = st_attr[wr_slot][3] ? bit_rev(wr_data) : wr_data;

  // The x write's valid set is issued after the line_start clear so it survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        st_attr[i] <= '0;
        st_pat0[i] <= '0;
        st_pat1[i] <= '0;
        st_x[i]    <= '0;
      end
    end else begin
      if (line_start) st_valid <= '0;
      if (wr_hit) begin
        case (wr_sel)
          2'd0: st_attr[wr_slot] <= {wr_data[6], wr_data[5], wr_data[1:0]};
          2'd1: st_pat0[wr_slot] <= wr_pat;
          2'd2: st_pat1[wr_slot] <= wr_pat;
          default: begin
            st_x[wr_slot]     <= wr_data;
            st_valid[wr_slot] <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    win_px  = '0;
    win_pri = 1'b0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_SPR; i++) begin
      cand = {sr1[i][7], sr0[i][7]};
      if (!found && act_valid[i] && (xc[i] == 8'd0) && (cand != 2'b00)) begin
        found   = 1'b1;
        win_px  = {a_attr[i][1:0], cand};
        win_pri = a_attr[i][2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_valid <= '0;
      px        <= '0;
      pri       <= 1'b0;
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        a_attr[i] <= '0;
        sr0[i]    <= '0;
        sr1[i]    <= '0;
        xc[i]     <= '0;
      end
    end else if (line_start) begin
      act_valid <= st_valid;
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        a_attr[i] <= st_attr[i][2:0];
        sr0[i]    <= st_pat0[i];
        sr1[i]    <= st_pat1[i];
        xc[i]     <= st_x[i];
      end
    end else if (px_en) begin
      px  <= win_px;
      pri <= win_pri;
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        if (xc[i] != 8'd0) begin
          xc[i] <= xc[i] - 8'd1;
        end else begin
          sr0[i] <= {sr0[i][6:0], 1'b0};
          sr1[i] <= {sr1[i][6:0], 1'b0};
        end
      end
    end
  end

`ifdef SPR_ZERO_HIT_EN
  logic spr0_flag;
  logic s0_hit;

  assign s0_hit = act_valid[0] && (xc[0] == 8'd0) && (sr0[0][7] || sr1[0][7]) && spr0_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      spr0_flag <= 1'b0;
      spr0_px   <= 1'b0;
    end else if (line_start) begin
      spr0_flag <= spr0_in;
    end else if (px_en) begin
      spr0_px <= s0_hit;
    end
  end
`else
  logic spr0_unused;
  assign spr0_unused = spr0_in;
  assign spr0_px     = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_bank.sv
// Scoreboard bench for sprite_bank: a per-line pixel-image model predicts every px_en result.
module tb_sprite_bank;

  localparam int NUM = 6;
  localparam int SW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          px_en = 1'b0;
  logic          line_start = 1'b0;
  logic          wr_en = 1'b0;
  logic [SW-1:0] wr_slot = '0;
  logic [1:0]    wr_sel = '0;
  logic [7:0]    wr_data = '0;
  logic          spr0_in = 1'b0;
  logic [3:0]    px;
  logic          pri;
  logic          spr0_px;

  sprite_bank #(.NUM_SPR(NUM)) dut (
    .clk(clk), .rst(rst), .px_en(px_en), .line_start(line_start),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_sel(wr_sel), .wr_data(wr_data),
    .spr0_in(spr0_in), .px(px), .pri(pri), .spr0_px(spr0_px)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pushes = 0;
  int pops = 0;

  // Reference model: staged values and the sprites of the current line
  logic [7:0] st_attr [NUM];
  logic [7:0] st_p0   [NUM];
  logic [7:0] st_p1   [NUM];
  int         st_x    [NUM];
  bit         st_v    [NUM];
  logic [7:0] ln_attr [NUM];
  logic [7:0] ln_p0   [NUM];
  logic [7:0] ln_p1   [NUM];
  int         ln_x    [NUM];
  bit         ln_v    [NUM];
  bit         ln_flag;
  int         k;

  logic [5:0] exp_q[$];
  logic       fire = 1'b0;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = d[7-b];
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NUM; s++) begin
      st_attr[s] = 0; st_p0[s] = 0; st_p1[s] = 0; st_x[s] = 0; st_v[s] = 0;
      ln_attr[s] = 0; ln_p0[s] = 0; ln_p1[s] = 0; ln_x[s] = 0; ln_v[s] = 0;
    end
    ln_flag = 0;
    k = 0;
  endtask

  task automatic model_write(input int slot, input int sel, input logic [7:0] d);
    if (slot < NUM) begin
      case (sel)
        0: st_attr[slot] = d;
        1: st_p0[slot] = st_attr[slot][6] ? rev8(d) : d;
        2: st_p1[slot] = st_attr[slot][6] ? rev8(d) : d;
        default: begin st_x[slot] = d; st_v[slot] = 1; end
      endcase
    end
  endtask

  task automatic model_promote(input bit s0);
    for (int s = 0; s < NUM; s++) begin
      ln_attr[s] = st_attr[s]; ln_p0[s] = st_p0[s]; ln_p1[s] = st_p1[s];
      ln_x[s] = st_x[s]; ln_v[s] = st_v[s]; st_v[s] = 0;
    end
`ifdef SPR_ZERO_HIT_EN
    ln_flag = s0;
`else
    ln_flag = 0;
    if (s0) ln_flag = 0;
`endif
    k = 0;
  endtask

  // Pixel p of the line: a sprite at x covers p = x..x+7, MSB first, lowest slot wins
  function automatic logic [5:0] model_pixel(input int p);
    logic [3:0] e_px;
    logic       e_pri;
    logic       e_s0;
    logic [1:0] pt;
    bit         found;
    int         b;
    e_px = 0; e_pri = 0; e_s0 = 0; found = 0;
    for (int s = 0; s < NUM; s++) begin
      if (ln_v[s] && p >= ln_x[s] && p < ln_x[s] + 8) begin
        b  = 7 - (p - ln_x[s]);
        pt = {ln_p1[s][b], ln_p0[s][b]};
        if (pt != 0) begin
          if (!found) begin
            found = 1; e_px = {ln_attr[s][1:0], pt}; e_pri = ln_attr[s][5];
          end
          if (s == 0 && ln_flag) e_s0 = 1;
        end
      end
    end
    return {e_px, e_pri, e_s0};
  endfunction

  // All tasks start and end at a negedge
  task automatic wr(input int slot, input int sel, input logic [7:0] d);
    wr_en = 1; wr_slot = SW'(slot); wr_sel = 2'(sel); wr_data = d;
    model_write(slot, sel, d);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic ls(input bit s0, input bit with_px);
    line_start = 1; spr0_in = s0; px_en = with_px;
    model_promote(s0);
    @(negedge clk);
    line_start = 0; px_en = 0; spr0_in = 0;
  endtask

  task automatic ls_wr(input bit s0, input int slot, input int sel, input logic [7:0] d);
    line_start = 1; spr0_in = s0;
    wr_en = 1; wr_slot = SW'(slot); wr_sel = 2'(sel); wr_data = d;
    model_promote(s0);
    model_write(slot, sel, d);
    @(negedge clk);
    line_start = 0; spr0_in = 0; wr_en = 0;
  endtask

  task automatic pxe();
    px_en = 1;
    exp_q.push_back(model_pixel(k));
    pushes++;
    k++;
    @(negedge clk);
    px_en = 0;
  endtask

  task automatic run_px(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      pxe();
      if (gaps && $urandom_range(0, 5) == 0) @(negedge clk);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({px, pri, spr0_px} !== 6'b0) begin
      failures++;
      $display("FAIL %s: got px=%b pri=%b spr0_px=%b, want all zero", name, px, pri, spr0_px);
    end
  endtask

  always @(posedge clk) fire <= px_en && !line_start && !rst;

  always @(negedge clk) begin
    logic [5:0] e;
    if (fire) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pixel_unexpected: got px=%b pri=%b spr0_px=%b with no pending expectation", px, pri, spr0_px);
      end else begin
        e = exp_q.pop_front();
        pops++;
        if ({px, pri, spr0_px} !== e) begin
          failures++;
          $display("FAIL pixel#%0d: got px=%b pri=%b spr0_px=%b, want px=%b pri=%b spr0_px=%b",
                   pops, px, pri, spr0_px, e[5:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    model_reset();
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    check_idle("reset_state");

    // Slot 3 at x=10, palette 2
    wr(3, 0, 8'h02); wr(3, 1, 8'hF0); wr(3, 2, 8'h00); wr(3, 3, 8'd10);
    ls(0, 0); run_px(256, 0);

    // Flipped slot 0 at x=0
    wr(0, 0, 8'h41); wr(0, 1, 8'h01); wr(0, 2, 8'h00); wr(0, 3, 8'd0);
    ls(0, 0); run_px(256, 0);

    // Overlap: slot 1 beats slot 2
    wr(1, 0, 8'h23); wr(1, 1, 8'hFF); wr(1, 2, 8'h00); wr(1, 3, 8'd20);
    wr(2, 0, 8'h20); wr(2, 1, 8'hFF); wr(2, 2, 8'h00); wr(2, 3, 8'd20);
    ls(0, 0); run_px(256, 1);

    // x=255 shows one pixel, then an empty line
    wr(5, 0, 8'h00); wr(5, 1, 8'h00); wr(5, 2, 8'hFF); wr(5, 3, 8'd255);
    ls(0, 0); run_px(256, 0);
    ls(0, 0); run_px(256, 0);

    // Sprite-0 hit: first without an x write, then with one
    wr(0, 0, 8'h00); wr(0, 1, 8'h80); wr(0, 2, 8'h00); wr(0, 0, 8'h00);
    ls(1, 0); run_px(256, 0);
    wr(0, 1, 8'h80); wr(0, 3, 8'd7);
    ls(1, 0); run_px(256, 0);

    // Writes to slots beyond NUM_SPR are dropped; write in the line_start cycle lands in new staging
    wr(6, 3, 8'd30); wr(7, 3, 8'd40);
    wr(4, 0, 8'h03); wr(4, 1, 8'hAA); wr(4, 2, 8'h55);
    ls_wr(0, 4, 3, 8'd50);
    run_px(256, 0);
    ls(0, 1); run_px(256, 0);

    // Reset in the middle of a live sprite
    wr(2, 0, 8'h01); wr(2, 1, 8'hFF); wr(2, 2, 8'h00); wr(2, 3, 8'd96);
    ls(0, 0); run_px(100, 0);
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
    check_idle("mid_line_reset");
    run_px(156, 0);
    ls(0, 0); run_px(256, 0);
    wr(2, 1, 8'hFF); wr(2, 3, 8'd96);
    ls(0, 0); run_px(256, 0);

    // Randomized lines
    for (int ln = 0; ln < 10; ln++) begin
      int nw;
      int mode;
      logic [7:0] d;
      nw = $urandom_range(3, 16);
      for (int w = 0; w < nw; w++) begin
        int sel;
        sel = $urandom_range(0, 3);
        d = 8'($urandom);
        if (sel == 3 && $urandom_range(0, 3) == 0) d = 8'(255 - $urandom_range(0, 8));
        wr($urandom_range(0, 7), sel, d);
      end
      mode = $urandom_range(0, 2);
      if (mode == 0) ls(1'($urandom), 0);
      else if (mode == 1) ls(1'($urandom), 1);
      else ls_wr(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3), 8'($urandom));
      run_px(256, 1);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || pops != pushes) begin
      failures++;
      $display("FAIL drain: got %0d outputs for %0d px_en pulses (%0d pending), want equal", pops, pushes, exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
